// File: rtl/v_mem_resp_pkg.sv
// Shared definitions for the vector-memory responder: FSM state codes,
// beat geometry, error reasons and the beat-lane slice helper.
`ifndef V_MEM_RESP_PKG_SV
`define V_MEM_RESP_PKG_SV

// Select beat lane k (width w) out of a packed vector; lane 0 is the LSBs.
`define V_MEM_LANE(vec, k, w) vec[(k)*(w) +: (w)]

package v_mem_resp_pkg;

    // A 512-bit vector moves as eight 64-bit SRAM beats.
    localparam int BEATS = 8;
    localparam int CNT_W = $clog2(BEATS);

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD      = 2'd1;
    localparam logic [1:0] ST_RD_TAIL = 2'd2;
    localparam logic [1:0] ST_WR      = 2'd3;

    // Error reasons. Only the read/write conflict is reported today;
    // misalignment is reserved for a future flag.
    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_RW_CONFLICT = 2'd1;
    localparam logic [1:0] ERR_MISALIGN    = 2'd2;

    // True on the final beat of a transfer.
    function automatic logic is_last(input logic [CNT_W-1:0] c);
        return c == CNT_W'(BEATS - 1);
    endfunction

endpackage

`endif

// File: rtl/v_mem_beat_pack.sv
// Beat packing datapath: holds the accepted write vector and serves one
// lane per beat, and assembles read beats into the output vector in place.
module v_mem_beat_pack
    import v_mem_resp_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic [CNT_W-1:0]  wsel,
    output logic [BEAT_W-1:0] wlane,
    input  logic              cap,
    input  logic [CNT_W-1:0]  cap_sel,
    input  logic [BEAT_W-1:0] rdata,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0]             wbuf;
    logic [BEATS-1:0][BEAT_W-1:0]  rbuf;

    // Latch the whole write vector when a write is accepted; later
    // changes on the request bus must not leak into the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    wbuf <= '0;
        else if (load) wbuf <= din;
    end

    assign wlane = `V_MEM_LANE(wbuf, wsel, BEAT_W);

    // Drop each returning read beat into its lane; other lanes keep the
    // previous vector until their own beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rbuf <= '0;
        else if (cap) rbuf[cap_sel] <= rdata;
    end

    assign dout = rbuf;

endmodule

// File: rtl/v_mem_resp.sv
// Vector-memory responder: turns one 512-bit read or write request into
// eight 64-bit accesses on a single-port SRAM with 1-cycle read latency.
module v_mem_resp
    import v_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int BEAT_W = 64,
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vmem_ren_i,
    input  logic              vmem_wen_i,
    input  logic [ADDR_W-1:0] vmem_raddr_i,
    input  logic [ADDR_W-1:0] vmem_waddr_i,
    input  logic [DATA_W-1:0] vmem_din_i,
    output logic              vmem_busy_o,
    output logic [DATA_W-1:0] vmem_dout_o,
    output logic              vmem_rvalid_o,
    output logic              vmem_wack_o,
    output logic              vmem_err_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [BEAT_W-1:0] ram_wdata_o,
    input  logic [BEAT_W-1:0] ram_rdata_i
);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [RAM_AW-1:0] base;
    logic              cap_vld;
    logic [CNT_W-1:0]  cap_idx;
    logic              rvalid_q, wack_q;
    logic [1:0]        err_code;
    logic              idle, take_wr, take_rd, last, in_rd, in_wr;
    logic [BEAT_W-1:0] wlane;

    // Byte-offset bits and bits above the SRAM range are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{vmem_raddr_i[ADDR_W-1:RAM_AW+3], vmem_raddr_i[2:0],
                                vmem_waddr_i[ADDR_W-1:RAM_AW+3], vmem_waddr_i[2:0]};

    assign idle    = (state == ST_IDLE);
    assign in_rd   = (state == ST_RD);
    assign in_wr   = (state == ST_WR);
    assign last    = is_last(cnt);
    // Write wins a read/write collision; the read must be re-presented.
    assign take_wr = idle && vmem_wen_i;
    assign take_rd = idle && vmem_ren_i && !vmem_wen_i;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (take_wr) state_nxt = ST_WR;
                        else if (take_rd) state_nxt = ST_RD;
            ST_RD:      if (last) state_nxt = ST_RD_TAIL;
            ST_RD_TAIL: state_nxt = ST_IDLE;
            ST_WR:      if (last) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State, beat counter and latched base word address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (in_rd || in_wr) ? cnt + CNT_W'(1) : '0;
            if (take_wr)      base <= vmem_waddr_i[RAM_AW+2:3];
            else if (take_rd) base <= vmem_raddr_i[RAM_AW+2:3];
        end
    end

    // Read data trails the SRAM address by one cycle; remember which lane
    // the returning beat belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
        end else begin
            cap_vld <= in_rd;
            cap_idx <= cnt;
        end
    end

    // Completion and error pulses, each one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            rvalid_q <= (state == ST_RD_TAIL);
            wack_q   <= in_wr && last;
            err_code <= (idle && vmem_ren_i && vmem_wen_i) ? ERR_RW_CONFLICT : ERR_NONE;
        end
    end

    v_mem_beat_pack #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W)
    ) u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (take_wr),
        .din     (vmem_din_i),
        .wsel    (cnt),
        .wlane   (wlane),
        .cap     (cap_vld),
        .cap_sel (cap_idx),
        .rdata   (ram_rdata_i),
        .dout    (vmem_dout_o)
    );

    // SRAM port is a pure decode of state so reset silences it at once.
    assign ram_en_o      = in_rd || in_wr;
    assign ram_we_o      = in_wr;
    assign ram_addr_o    = ram_en_o ? base + RAM_AW'(cnt) : '0;
    assign ram_wdata_o   = in_wr ? wlane : '0;

    assign vmem_busy_o   = !idle;
    assign vmem_rvalid_o = rvalid_q;
    assign vmem_wack_o   = wack_q;
    assign vmem_err_o    = (err_code == ERR_RW_CONFLICT);

endmodule

// File: tb/tb_v_mem_resp.sv
// Self-checking bench for v_mem_resp: behavioural SRAMs, a word-level
// reference memory, and one task per scenario.
module tb_v_mem_resp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Main instance, RAM_AW = 16
    logic         ren, wen;
    logic [63:0]  raddr, waddr;
    logic [511:0] din, dout;
    logic         busy, rvalid, wack, err, ram_en, ram_we;
    logic [15:0]  ram_addr;
    logic [63:0]  ram_wdata, ram_rdata;

    v_mem_resp dut (
        .clk(clk), .rst_n(rst_n),
        .vmem_ren_i(ren), .vmem_wen_i(wen),
        .vmem_raddr_i(raddr), .vmem_waddr_i(waddr), .vmem_din_i(din),
        .vmem_busy_o(busy), .vmem_dout_o(dout), .vmem_rvalid_o(rvalid),
        .vmem_wack_o(wack), .vmem_err_o(err),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    logic [63:0] mem [0:65535];
    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end

    // Small instance, RAM_AW = 4, for address wrap
    logic         s_ren, s_wen;
    logic [63:0]  s_raddr, s_waddr;
    logic [511:0] s_din, s_dout;
    logic         s_busy, s_rvalid, s_wack, s_err, s_en, s_we;
    logic [3:0]   s_addr;
    logic [63:0]  s_wdata, s_rdata;

    v_mem_resp #(.RAM_AW(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .vmem_ren_i(s_ren), .vmem_wen_i(s_wen),
        .vmem_raddr_i(s_raddr), .vmem_waddr_i(s_waddr), .vmem_din_i(s_din),
        .vmem_busy_o(s_busy), .vmem_dout_o(s_dout), .vmem_rvalid_o(s_rvalid),
        .vmem_wack_o(s_wack), .vmem_err_o(s_err),
        .ram_en_o(s_en), .ram_we_o(s_we), .ram_addr_o(s_addr),
        .ram_wdata_o(s_wdata), .ram_rdata_i(s_rdata)
    );

    logic [63:0] smem [0:15];
    always @(posedge clk)
        if (s_en) begin
            if (s_we) smem[s_addr] <= s_wdata;
            else      s_rdata <= smem[s_addr];
        end

    // Reference: word address -> 64-bit contents
    logic [63:0] ref_mem [int];

    function automatic logic [63:0] ref_rd(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return 64'h0;
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'((a / 64'd8) % 64'd65536);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [511:0] v);
        int b;
        b = word_of(a);
        wen = 1'b1; waddr = a; din = v;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 1) begin
                wen = 1'b0; waddr = {$urandom, $urandom}; din = {16{$urandom}};
            end
            if (j <= 8) begin
                checks++;
                if (busy !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_ctrl beat=%0d got busy=%b en=%b we=%b want 1 1 1", j-1, busy, ram_en, ram_we);
                end
                checks++;
                if (ram_addr !== 16'((b + j - 1) % 65536)) begin
                    errors++;
                    $display("FAIL wr_addr beat=%0d got %h want %h", j-1, ram_addr, 16'((b + j - 1) % 65536));
                end
                checks++;
                if (ram_wdata !== v[(j-1)*64 +: 64]) begin
                    errors++;
                    $display("FAIL wr_data beat=%0d got %h want %h", j-1, ram_wdata, v[(j-1)*64 +: 64]);
                end
                checks++;
                if (wack !== 1'b0 || rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_early_pulse beat=%0d got wack=%b rvalid=%b want 0 0", j-1, wack, rvalid);
                end
            end else begin
                checks++;
                if (wack !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_ack got wack=%b busy=%b want 1 0", wack, busy);
                end
            end
        end
        for (int k = 0; k < 8; k++) ref_mem[(b + k) % 65536] = v[k*64 +: 64];
    endtask

    task automatic do_read(input logic [63:0] a);
        int b;
        logic [511:0] exp;
        b = word_of(a);
        for (int k = 0; k < 8; k++) exp[k*64 +: 64] = ref_rd((b + k) % 65536);
        ren = 1'b1; raddr = a;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 1) begin
                ren = 1'b0; raddr = {$urandom, $urandom};
            end
            if (j <= 8) begin
                checks++;
                if (busy !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_ctrl beat=%0d got busy=%b en=%b we=%b rv=%b want 1 1 0 0", j-1, busy, ram_en, ram_we, rvalid);
                end
                checks++;
                if (ram_addr !== 16'((b + j - 1) % 65536)) begin
                    errors++;
                    $display("FAIL rd_addr beat=%0d got %h want %h", j-1, ram_addr, 16'((b + j - 1) % 65536));
                end
            end else if (j == 9) begin
                checks++;
                if (busy !== 1'b1 || ram_en !== 1'b0 || rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_tail got busy=%b en=%b rv=%b want 1 0 0", busy, ram_en, rvalid);
                end
            end else begin
                checks++;
                if (rvalid !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_valid got rv=%b busy=%b want 1 0", rvalid, busy);
                end
                checks++;
                if (dout !== exp) begin
                    errors++;
                    $display("FAIL rd_data got %h want %h", dout, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({busy, rvalid, wack, err, ram_en, ram_we} !== 6'b0 || ram_addr !== 16'h0 || ram_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b rv=%b wack=%b err=%b en=%b we=%b addr=%h wd=%h want all 0",
                     busy, rvalid, wack, err, ram_en, ram_we, ram_addr, ram_wdata);
        end
        checks++;
        if (dout !== 512'h0) begin
            errors++;
            $display("FAIL reset_dout got %h want 0", dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b s_busy=%b want 0 0", busy, s_busy);
        end
    endtask

    task automatic test_write_read();
        logic [511:0] v;
        for (int k = 0; k < 8; k++) v[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        do_write(64'h40, v);
        do_read(64'h40);
        do_read(64'h47);
    endtask

    task automatic test_conflict();
        logic [511:0] v, exp;
        logic         rv_seen;
        v = {16{$urandom}};
        for (int k = 0; k < 8; k++) exp[k*64 +: 64] = ref_rd(8 + k);
        rv_seen = 1'b0;
        ren = 1'b1; wen = 1'b1; waddr = 64'h80; raddr = 64'h40; din = v;
        for (int j = 1; j <= 19; j++) begin
            tick();
            if (j == 1) wen = 1'b0;
            if (j == 10) ren = 1'b0;
            if (j <= 18) rv_seen = rv_seen | rvalid;
            if (j == 1) begin
                checks++;
                if (err !== 1'b1) begin errors++; $display("FAIL conf_err got %b want 1", err); end
            end
            if (j == 2) begin
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL conf_err_width got %b want 0", err); end
            end
            if (j <= 8) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== 16'(16 + j - 1) || ram_wdata !== v[(j-1)*64 +: 64]) begin
                    errors++;
                    $display("FAIL conf_wr beat=%0d got we=%b addr=%h wd=%h want 1 %h %h",
                             j-1, ram_we, ram_addr, ram_wdata, 16'(16 + j - 1), v[(j-1)*64 +: 64]);
                end
            end
            if (j == 9) begin
                checks++;
                if (wack !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL conf_wack got wack=%b busy=%b want 1 0", wack, busy);
                end
            end
            if (j >= 10 && j <= 17) begin
                checks++;
                if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'(8 + j - 10)) begin
                    errors++;
                    $display("FAIL conf_reread beat=%0d got en=%b we=%b addr=%h want 1 0 %h", j-10, ram_en, ram_we, ram_addr, 16'(8 + j - 10));
                end
            end
            if (j == 19) begin
                checks++;
                if (rvalid !== 1'b1 || dout !== exp) begin
                    errors++; $display("FAIL conf_rdata got rv=%b dout=%h want 1 %h", rvalid, dout, exp);
                end
            end
        end
        checks++;
        if (rv_seen !== 1'b0) begin errors++; $display("FAIL conf_no_rvalid got 1 want 0"); end
        for (int k = 0; k < 8; k++) ref_mem[16 + k] = v[k*64 +: 64];
    endtask

    task automatic test_back_to_back();
        logic [511:0] ea, eb;
        logic         rv_extra;
        for (int k = 0; k < 8; k++) begin
            ea[k*64 +: 64] = ref_rd(8 + k);
            eb[k*64 +: 64] = ref_rd(16 + k);
        end
        rv_extra = 1'b0;
        ren = 1'b1; raddr = 64'h40;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (j == 1) raddr = 64'h80;   // only sampled again once idle
            if (j == 11) ren = 1'b0;
            if (j != 10 && j != 20) rv_extra = rv_extra | rvalid;
            if (j <= 8 || (j >= 11 && j <= 18)) begin
                checks++;
                if (ram_en !== 1'b1 || ram_addr !== 16'(j <= 8 ? 8 + j - 1 : 16 + j - 11)) begin
                    errors++;
                    $display("FAIL b2b_addr cyc=%0d got en=%b addr=%h want 1 %h", j, ram_en, ram_addr, 16'(j <= 8 ? 8 + j - 1 : 16 + j - 11));
                end
            end
            if (j == 9) begin
                checks++;
                if (ram_en !== 1'b0) begin errors++; $display("FAIL b2b_gap got en=%b want 0", ram_en); end
            end
            if (j == 10 || j == 20) begin
                checks++;
                if (rvalid !== 1'b1 || dout !== (j == 10 ? ea : eb)) begin
                    errors++;
                    $display("FAIL b2b_data cyc=%0d got rv=%b dout=%h want 1 %h", j, rvalid, dout, (j == 10 ? ea : eb));
                end
            end
        end
        checks++;
        if (rv_extra !== 1'b0) begin errors++; $display("FAIL b2b_extra_rvalid got 1 want 0"); end
    endtask

    task automatic test_wrap();
        logic [511:0] v;
        v = {16{$urandom}};
        s_wen = 1'b1; s_waddr = 64'h78; s_din = v;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 1) s_wen = 1'b0;
            if (j <= 8) begin
                checks++;
                if (s_we !== 1'b1 || s_addr !== 4'((15 + j - 1) % 16)) begin
                    errors++;
                    $display("FAIL wrap_wr_addr beat=%0d got we=%b addr=%h want 1 %h", j-1, s_we, s_addr, 4'((15 + j - 1) % 16));
                end
            end else begin
                checks++;
                if (s_wack !== 1'b1) begin errors++; $display("FAIL wrap_wack got %b want 1", s_wack); end
            end
        end
        s_ren = 1'b1; s_raddr = 64'h7C;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 1) s_ren = 1'b0;
            if (j <= 8) begin
                checks++;
                if (s_en !== 1'b1 || s_we !== 1'b0 || s_addr !== 4'((15 + j - 1) % 16)) begin
                    errors++;
                    $display("FAIL wrap_rd_addr beat=%0d got en=%b we=%b addr=%h want 1 0 %h", j-1, s_en, s_we, s_addr, 4'((15 + j - 1) % 16));
                end
            end
            if (j == 10) begin
                checks++;
                if (s_rvalid !== 1'b1 || s_dout !== v) begin
                    errors++; $display("FAIL wrap_rdata got rv=%b dout=%h want 1 %h", s_rvalid, s_dout, v);
                end
                checks++;
                if (s_dout[127:64] !== smem[0]) begin
                    errors++; $display("FAIL wrap_lane1 got %h want %h", s_dout[127:64], smem[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] v1, v2;
        logic         wack_seen;
        v1 = {16{$urandom}};
        v2 = {16{$urandom}};
        do_write(64'h200, v1);
        wen = 1'b1; waddr = 64'h200; din = v2;
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j == 1) wen = 1'b0;
        end
        // Let the edge that commits beat 3 happen, then abort.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ram_en, ram_we, wack, rvalid} !== 5'b0 || ram_addr !== 16'h0 || dout !== 512'h0) begin
            errors++;
            $display("FAIL midrst_outputs got busy=%b en=%b we=%b wack=%b rv=%b addr=%h dout_nz=%b want all 0",
                     busy, ram_en, ram_we, wack, rvalid, ram_addr, |dout);
        end
        wack_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            wack_seen = wack_seen | wack;
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem[64 + k] !== (k < 4 ? v2[k*64 +: 64] : v1[k*64 +: 64])) begin
                errors++;
                $display("FAIL midrst_mem word=%0d got %h want %h", 64 + k, mem[64 + k], (k < 4 ? v2[k*64 +: 64] : v1[k*64 +: 64]));
            end
            ref_mem[64 + k] = (k < 4) ? v2[k*64 +: 64] : v1[k*64 +: 64];
        end
        rst_n = 1'b1;
        tick();
        wack_seen = wack_seen | wack;
        checks++;
        if (wack_seen !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_after got wack_seen=%b busy=%b want 0 0", wack_seen, busy);
        end
        do_read(64'h200);
    endtask

    task automatic test_random();
        logic [63:0] wq[$];
        logic [63:0] a;
        for (int i = 0; i < 10; i++) begin
            if (wq.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = {$urandom, $urandom};
                do_write(a, {16{$urandom}});
                wq.push_back(a);
            end else begin
                a = wq[$urandom_range(0, wq.size() - 1)];
                a[2:0]   = 3'($urandom);
                a[63:40] = 24'($urandom);
                do_read(a);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ren = 1'b0; wen = 1'b0; raddr = '0; waddr = '0; din = '0;
        s_ren = 1'b0; s_wen = 1'b0; s_raddr = '0; s_waddr = '0; s_din = '0;
        test_reset();
        test_write_read();
        test_conflict();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
